// File: rtl/les_cipher_sink.sv
// Ciphertext sink for the LES core: captures each finished encryption, folds it into
// a rotate-XOR signature and counter, and re-serialises it MSB first through a one-word buffer.
module les_cipher_sink #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             ICE_CLK,
   input  logic             resetn,
   input  logic             busy,
   input  logic [WIDTH-1:0] cipher_in,
   input  logic             clr,
   output logic [WIDTH-1:0] sig_out,
   output logic [CNT_W-1:0] count_out,
   output logic             ser_dout,
   output logic             ser_frame,
   output logic             overrun
);

   localparam int BC_W = $clog2(WIDTH);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic [WIDTH-1:0]  sig_q, sig_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overrun_q, overrun_d;
   logic [WIDTH-1:0]  pend_q, pend_d;
   logic              pend_v_q, pend_v_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [BC_W-1:0]   bitcnt_q, bitcnt_d;

   logic cap;
   logic drain;

   assign cap   = busy_q & ~busy;
   // The buffer empties in the same cycle a new capture may refill it.
   assign drain = (state_q == IDLE) & pend_v_q;

   always_ff @(posedge ICE_CLK) begin
      if (!resetn) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         sig_q     <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         pend_q    <= '0;
         pend_v_q  <= 1'b0;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         sig_q     <= sig_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         pend_q    <= pend_d;
         pend_v_q  <= pend_v_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
      end
   end

   always_comb begin
      busy_d    = busy;
      sig_d     = sig_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      pend_d    = pend_q;
      pend_v_d  = pend_v_q;
      // Clear wins over a coincident capture for the signature side only.
      if (clr) begin
         sig_d     = '0;
         count_d   = '0;
         overrun_d = 1'b0;
      end else if (cap) begin
         sig_d   = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ cipher_in;
         count_d = count_q + 1'b1;
         if (pend_v_q && !drain) begin
            overrun_d = 1'b1;
         end
      end
      if (drain) begin
         pend_v_d = 1'b0;
      end
      if (cap && (!pend_v_q || drain)) begin
         pend_d   = cipher_in;
         pend_v_d = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      case (state_q)
         IDLE: begin
            if (pend_v_q) begin
               state_d  = SHIFT;
               shreg_d  = pend_q;
               bitcnt_d = '0;
            end
         end
         SHIFT: begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == LAST_BIT) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ser_frame = 1'b0;
      ser_dout  = 1'b0;
      if (state_q == SHIFT) begin
         ser_frame = 1'b1;
         ser_dout  = shreg_q[WIDTH-1];
      end
   end

   assign sig_out   = sig_q;
   assign count_out = count_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_les_cipher_sink.sv
// Randomised scoreboard bench for les_cipher_sink: a timing-level model predicts signature,
// count, overrun and the start cycle of every serial frame; a monitor reassembles frames.
module tb_les_cipher_sink;

   logic        ICE_CLK = 1'b0;
   logic        resetn;
   logic        busy;
   logic [31:0] cipher_in;
   logic        clr;
   logic [31:0] sig_out;
   logic [15:0] count_out;
   logic        ser_dout;
   logic        ser_frame;
   logic        overrun;
   logic [31:0] sig4;
   logic [3:0]  count4;
   logic        dout4;
   logic        frame4;
   logic        ov4;

   les_cipher_sink #(.WIDTH(32), .CNT_W(16)) dut (
      .ICE_CLK(ICE_CLK), .resetn(resetn), .busy(busy), .cipher_in(cipher_in), .clr(clr),
      .sig_out(sig_out), .count_out(count_out), .ser_dout(ser_dout), .ser_frame(ser_frame),
      .overrun(overrun)
   );

   // Narrow-counter instance on the same inputs, so counter wrap is reached quickly.
   les_cipher_sink #(.WIDTH(32), .CNT_W(4)) dut4 (
      .ICE_CLK(ICE_CLK), .resetn(resetn), .busy(busy), .cipher_in(cipher_in), .clr(clr),
      .sig_out(sig4), .count_out(count4), .ser_dout(dout4), .ser_frame(frame4),
      .overrun(ov4)
   );

   always #5 ICE_CLK = ~ICE_CLK;

   int cyc = 0;
   always @(posedge ICE_CLK) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] w;
      int          start;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state
   logic [31:0] sig_m;
   int          cnt_m;
   logic        ov_m;
   int          idle_from;
   int          last_depart;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge ICE_CLK);
      #1;
   endtask

   task automatic model_reset();
      sig_m       = '0;
      cnt_m       = 0;
      ov_m        = 1'b0;
      idle_from   = 0;
      last_depart = 0;
      exp_q.delete();
   endtask

   // A word entering the buffer at t+1 leaves it once the serializer is idle;
   // a capture is refused while an earlier word is still waiting to leave.
   task automatic model_cap(input logic [31:0] w, input logic c, input int t);
      bit   accept;
      int   d;
      exp_t e;
      accept = (t >= last_depart);
      if (c) begin
         sig_m = '0;
         cnt_m = 0;
         ov_m  = 1'b0;
      end else begin
         sig_m = ((sig_m << 1) | (sig_m >> 31)) ^ w;
         cnt_m = cnt_m + 1;
         if (!accept) ov_m = 1'b1;
      end
      if (accept) begin
         d           = (t + 1 > idle_from) ? t + 1 : idle_from;
         e.w         = w;
         e.start     = d + 1;
         exp_q.push_back(e);
         idle_from   = d + 33;
         last_depart = d;
      end
   endtask

   task automatic check_state();
      chk("sig_out", sig_out, sig_m);
      chk("count_out", {16'h0, count_out}, cnt_m & 32'hFFFF);
      chk("count4", {28'h0, count4}, cnt_m & 32'hF);
      chk("overrun", {31'h0, overrun}, {31'h0, ov_m});
   endtask

   task automatic cap_word(input logic [31:0] w, input int hi, input logic c);
      busy = 1'b1;
      repeat (hi) tick();
      busy      = 1'b0;
      cipher_in = w;
      clr       = c;
      model_cap(w, c, cyc);
      tick();
      clr       = 1'b0;
      cipher_in = $urandom;
      check_state();
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 3000 && (exp_q.size() != 0 || ser_frame); i++) tick();
      tick();
      chk("idle_timeout", (exp_q.size() != 0 || ser_frame) ? 32'd1 : 32'd0, 32'd0);
   endtask

   // Frame monitor
   int          nbits = 0;
   int          fstart = 0;
   logic [31:0] acc = '0;
   bit          abort_ok = 1'b0;

   always @(negedge ICE_CLK) begin
      exp_t e;
      if (ser_frame) begin
         if (nbits == 0) fstart = cyc;
         acc = {acc[30:0], ser_dout};
         nbits++;
      end else begin
         chk("idle_dout", {31'h0, ser_dout}, 32'd0);
         if (nbits != 0) begin
            if (abort_ok) begin
               abort_ok = 1'b0;
            end else if (nbits != 32) begin
               chk("frame_len", nbits, 32);
            end else if (exp_q.size() == 0) begin
               chk("unexpected_frame", acc, 32'hxxxxxxxx);
            end else begin
               e = exp_q.pop_front();
               chk("frame_word", acc, e.w);
               chk("frame_start", fstart, e.start);
            end
            nbits = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn    = 1'b0;
      busy      = 1'b1;
      cipher_in = '0;
      clr       = 1'b0;
      model_reset();
      repeat (3) tick();
      chk("rst_sig", sig_out, 32'h0);
      chk("rst_count", {16'h0, count_out}, 32'h0);
      chk("rst_dout", {31'h0, ser_dout}, 32'h0);
      chk("rst_frame", {31'h0, ser_frame}, 32'h0);
      chk("rst_overrun", {31'h0, overrun}, 32'h0);
      resetn = 1'b1;
      busy   = 1'b0;
      repeat (3) tick();
      chk("no_cap_after_rst", {16'h0, count_out}, 32'h0);

      cap_word(32'hDEADBEEF, 5, 1'b0);
      chk("single_sig", sig_out, 32'hDEADBEEF);
      repeat (4) tick();
      cap_word(32'h12345678, 5, 1'b0);
      chk("chain_sig", sig_out, 32'hAF6F2BA7);
      chk("chain_count", {16'h0, count_out}, 32'd2);
      wait_idle();

      cap_word(32'h11111111, 2, 1'b0);
      cap_word(32'h22222222, 2, 1'b0);
      cap_word(32'h33333333, 2, 1'b0);
      chk("overrun_set", {31'h0, overrun}, 32'd1);
      chk("overrun_count", {16'h0, count_out}, 32'd5);
      wait_idle();

      cap_word(32'hCAFEF00D, 3, 1'b1);
      chk("clr_sig", sig_out, 32'h0);
      chk("clr_ovr", {31'h0, overrun}, 32'h0);
      wait_idle();

      repeat (16) cap_word($urandom, 1, 1'b0);
      chk("wrap4", {28'h0, count4}, 32'h0);
      chk("wrap16", {16'h0, count_out}, 32'd16);

      for (int i = 0; i < 150; i++) begin
         cap_word($urandom, $urandom_range(1, 40), ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 11) == 0) begin
            clr = 1'b1;
            sig_m = '0;
            cnt_m = 0;
            ov_m  = 1'b0;
            tick();
            clr = 1'b0;
            check_state();
         end
      end
      wait_idle();

      cap_word(32'hA5C3F00F, 3, 1'b0);
      repeat (10) tick();
      chk("mid_frame", {31'h0, ser_frame}, 32'd1);
      abort_ok = 1'b1;
      resetn   = 1'b0;
      model_reset();
      tick();
      chk("abort_frame", {31'h0, ser_frame}, 32'h0);
      chk("abort_dout", {31'h0, ser_dout}, 32'h0);
      chk("abort_sig", sig_out, 32'h0);
      chk("abort_count", {16'h0, count_out}, 32'h0);
      chk("abort_ovr", {31'h0, overrun}, 32'h0);
      resetn = 1'b1;
      repeat (40) tick();
      chk("post_rst_count", {16'h0, count_out}, 32'h0);
      chk("post_rst_frame", {31'h0, ser_frame}, 32'h0);
      chk("post_rst_queue", exp_q.size(), 32'd0);
      abort_ok = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
